// File: rtl/pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl
//
// Central stall / flush / bubble controller for the 5-stage in-order
// pipeline. It drives the IF/ID and ID/EX register controls from:
//   - the ID source-register usage;
//   - the EX destination, load, redirect and multi-cycle-op status;
//   - the MEM-stage LSU busy flag.
//
// Event priority, highest first:
//   lsu_busy > MDU wait > redirect/flush > load-use > none
//
// Parameters
//   FLUSH_CYCLES  cycles if_flush/id_flush stay high after a redirect (1..7)
//   MDU_TIMEOUT   cycles in MDU_WAIT before mdu_timeout is raised (2..255)
//
// Ports
//   clock, reset          clock and synchronous active-high reset
//   id_valid              ID holds a valid instruction
//   id_rs1_use/rs2_use    ID instruction reads rs1/rs2
//   id_rs1/rs2_addr       source register indices
//   ex_valid              EX holds a valid instruction
//   ex_w_ena              EX instruction writes the register file
//   ex_w_addr             EX destination index
//   ex_is_load            EX instruction is a load
//   ex_redirect           taken branch/jump resolved in EX (pulse)
//   mdu_start             multi-cycle mul/div issued this cycle
//   mdu_done              MDU result ready (pulse)
//   lsu_busy              MEM stage waiting on memory
//   if_stall              hold PC and IF/ID
//   id_stall              hold ID/EX
//   ex_stall              hold EX/MEM
//   id_nop                insert a bubble into ID/EX
//   if_flush              squash IF/ID
//   id_flush              squash ID/EX
//   ctrl_state            0=RUN 1=MDU_WAIT 2=MEM_WAIT 3=FLUSH
//   mdu_timeout           sticky MDU timeout flag, cleared only by reset
//
// Optional build macro: PIPE_HAZARD_CTRL_PERF_EN
//   Adds three 32-bit wrapping performance counters:
//     perf_loaduse_cnt   load-use bubbles inserted
//     perf_stall_cnt     cycles with ex_stall high
//     perf_flush_cnt     redirects accepted
// ---------------------------------------------------------------------------
module pipe_hazard_ctrl #(
  parameter int FLUSH_CYCLES = 2,
  parameter int MDU_TIMEOUT  = 64
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        id_valid,
  input  logic        id_rs1_use,
  input  logic        id_rs2_use,
  input  logic [4:0]  id_rs1_addr,
  input  logic [4:0]  id_rs2_addr,
  input  logic        ex_valid,
  input  logic        ex_w_ena,
  input  logic [4:0]  ex_w_addr,
  input  logic        ex_is_load,
  input  logic        ex_redirect,
  input  logic        mdu_start,
  input  logic        mdu_done,
  input  logic        lsu_busy,
  output logic        if_stall,
  output logic        id_stall,
  output logic        ex_stall,
  output logic        id_nop,
  output logic        if_flush,
  output logic        id_flush,
  output logic [1:0]  ctrl_state,
  output logic        mdu_timeout
`ifdef PIPE_HAZARD_CTRL_PERF_EN
  ,
  output logic [31:0] perf_loaduse_cnt,
  output logic [31:0] perf_stall_cnt,
  output logic [31:0] perf_flush_cnt
`endif
);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MDU_WAIT = 2'd1,
    ST_MEM_WAIT = 2'd2,
    ST_FLUSH    = 2'd3
  } state_t;

  localparam logic [2:0] FLUSH_RELOAD = 3'(FLUSH_CYCLES - 1);
  localparam logic [7:0] MDU_LIMIT    = 8'(MDU_TIMEOUT);

  state_t     state_q, state_d;
  state_t     saved_q, saved_d;
  logic [2:0] flush_cnt_q, flush_cnt_d;
  logic [7:0] mdu_cnt_q, mdu_cnt_d;
  logic       timeout_q, timeout_d;
  logic       load_use;

  // Counter that holds at its limit instead of wrapping.
  function automatic logic [7:0] sat_inc(input logic [7:0] v, input logic [7:0] lim);
    return (v >= lim) ? v : v + 8'd1;
  endfunction

  // Register zero is never a real dependency, so a load to x0 never stalls.
  assign load_use = id_valid && ex_valid && ex_is_load && ex_w_ena &&
                    (ex_w_addr != 5'd0) &&
                    ((id_rs1_use && (id_rs1_addr == ex_w_addr)) ||
                     (id_rs2_use && (id_rs2_addr == ex_w_addr)));

  // Next-state and output decode
  always_comb begin
    state_d     = state_q;
    saved_d     = saved_q;
    flush_cnt_d = flush_cnt_q;
    mdu_cnt_d   = mdu_cnt_q;
    timeout_d   = timeout_q;
    if_stall    = 1'b0;
    id_stall    = 1'b0;
    ex_stall    = 1'b0;
    id_nop      = 1'b0;
    if_flush    = 1'b0;
    id_flush    = 1'b0;

    case (state_q)
      ST_RUN: begin
        if (lsu_busy) begin
          saved_d  = ST_RUN;
          state_d  = ST_MEM_WAIT;
          if_stall = 1'b1;
          id_stall = 1'b1;
          ex_stall = 1'b1;
        end else if (ex_redirect) begin
          if_flush    = 1'b1;
          id_flush    = 1'b1;
          flush_cnt_d = FLUSH_RELOAD;
          state_d     = (FLUSH_CYCLES > 1) ? ST_FLUSH : ST_RUN;
        end else if (mdu_start) begin
          // Stalls start once the state register shows MDU_WAIT.
          state_d   = ST_MDU_WAIT;
          mdu_cnt_d = 8'd0;
        end else if (load_use) begin
          if_stall = 1'b1;
          id_nop   = 1'b1;
        end
      end

      ST_MDU_WAIT: begin
        if (mdu_done) begin
          state_d = ST_RUN;
        end else begin
          if_stall = 1'b1;
          id_stall = 1'b1;
          ex_stall = 1'b1;
          if (lsu_busy) begin
            // Counter is frozen for the whole memory wait.
            saved_d = ST_MDU_WAIT;
            state_d = ST_MEM_WAIT;
          end else begin
            mdu_cnt_d = sat_inc(mdu_cnt_q, MDU_LIMIT);
            if (mdu_cnt_d == MDU_LIMIT) begin
              timeout_d = 1'b1;
            end
          end
        end
      end

      ST_MEM_WAIT: begin
        // Redirects are ignored here; EX is frozen and will re-pulse.
        if (lsu_busy) begin
          if_stall = 1'b1;
          id_stall = 1'b1;
          ex_stall = 1'b1;
        end else begin
          state_d = saved_q;
        end
      end

      ST_FLUSH: begin
        if (lsu_busy) begin
          // flush_cnt_q is left untouched so the flush resumes on return.
          saved_d  = ST_FLUSH;
          state_d  = ST_MEM_WAIT;
          if_stall = 1'b1;
          id_stall = 1'b1;
          ex_stall = 1'b1;
        end else begin
          if_flush = 1'b1;
          id_flush = 1'b1;
          if (ex_redirect) begin
            flush_cnt_d = FLUSH_RELOAD;
          end else if (flush_cnt_q <= 3'd1) begin
            flush_cnt_d = 3'd0;
            state_d     = ST_RUN;
          end else begin
            flush_cnt_d = flush_cnt_q - 3'd1;
          end
        end
      end

      default: state_d = ST_RUN;
    endcase
  end

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_RUN;
      saved_q     <= ST_RUN;
      flush_cnt_q <= 3'd0;
      mdu_cnt_q   <= 8'd0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      saved_q     <= saved_d;
      flush_cnt_q <= flush_cnt_d;
      mdu_cnt_q   <= mdu_cnt_d;
      timeout_q   <= timeout_d;
    end
  end

  assign ctrl_state  = state_q;
  assign mdu_timeout = timeout_q;

`ifdef PIPE_HAZARD_CTRL_PERF_EN
  logic redirect_taken;

  // A redirect counts only where it actually starts or restarts a flush.
  assign redirect_taken = ex_redirect && !lsu_busy &&
                          ((state_q == ST_RUN) || (state_q == ST_FLUSH));

  // Performance counters
  always_ff @(posedge clock) begin
    if (reset) begin
      perf_loaduse_cnt <= 32'd0;
      perf_stall_cnt   <= 32'd0;
      perf_flush_cnt   <= 32'd0;
    end else begin
      if (id_nop)         perf_loaduse_cnt <= perf_loaduse_cnt + 32'd1;
      if (ex_stall)       perf_stall_cnt   <= perf_stall_cnt + 32'd1;
      if (redirect_taken) perf_flush_cnt   <= perf_flush_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
module tb_pipe_hazard_ctrl;

  localparam int FC = 2;
  localparam int MT = 4;

  localparam logic [5:0] STALL  = 6'b111000;
  localparam logic [5:0] BUBBLE = 6'b100100;
  localparam logic [5:0] FLUSH  = 6'b000011;
  localparam logic [5:0] NONE   = 6'b000000;

  logic       clock;
  logic       reset;
  logic       id_valid, id_rs1_use, id_rs2_use;
  logic [4:0] id_rs1_addr, id_rs2_addr;
  logic       ex_valid, ex_w_ena, ex_is_load, ex_redirect;
  logic [4:0] ex_w_addr;
  logic       mdu_start, mdu_done, lsu_busy;
  logic       if_stall, id_stall, ex_stall, id_nop, if_flush, id_flush;
  logic [1:0] ctrl_state;
  logic       mdu_timeout;
`ifdef PIPE_HAZARD_CTRL_PERF_EN
  logic [31:0] perf_loaduse_cnt, perf_stall_cnt, perf_flush_cnt;
`endif

  logic [5:0] obs;
  assign obs = {if_stall, id_stall, ex_stall, id_nop, if_flush, id_flush};

  int vectors    = 0;
  int miscompares = 0;

  // Reference model: pending conditions rather than an encoded state.
  bit m_mem;
  bit m_mdu;
  int m_flush_left;
  int m_elapsed;
  bit m_timeout;
  int m_lu_cnt, m_stall_cnt, m_redirects;

  pipe_hazard_ctrl #(.FLUSH_CYCLES(FC), .MDU_TIMEOUT(MT)) dut (
    .clock(clock), .reset(reset),
    .id_valid(id_valid), .id_rs1_use(id_rs1_use), .id_rs2_use(id_rs2_use),
    .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
    .ex_valid(ex_valid), .ex_w_ena(ex_w_ena), .ex_w_addr(ex_w_addr),
    .ex_is_load(ex_is_load), .ex_redirect(ex_redirect),
    .mdu_start(mdu_start), .mdu_done(mdu_done), .lsu_busy(lsu_busy),
    .if_stall(if_stall), .id_stall(id_stall), .ex_stall(ex_stall),
    .id_nop(id_nop), .if_flush(if_flush), .id_flush(id_flush),
    .ctrl_state(ctrl_state), .mdu_timeout(mdu_timeout)
`ifdef PIPE_HAZARD_CTRL_PERF_EN
    , .perf_loaduse_cnt(perf_loaduse_cnt), .perf_stall_cnt(perf_stall_cnt),
    .perf_flush_cnt(perf_flush_cnt)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic idle();
    id_valid = 0; id_rs1_use = 0; id_rs2_use = 0;
    id_rs1_addr = 0; id_rs2_addr = 0;
    ex_valid = 0; ex_w_ena = 0; ex_w_addr = 0; ex_is_load = 0;
    ex_redirect = 0; mdu_start = 0; mdu_done = 0; lsu_busy = 0;
  endtask

  task automatic pulse_reset();
    idle();
    reset = 1;
    @(negedge clock);
    reset = 0;
  endtask

  task automatic set_load_use(input logic [4:0] dst);
    id_valid = 1; ex_valid = 1; ex_is_load = 1; ex_w_ena = 1;
    ex_w_addr = dst; id_rs2_addr = 5'd5; id_rs2_use = 1;
  endtask

  task automatic model_clear();
    m_mem = 0; m_mdu = 0; m_flush_left = 0; m_elapsed = 0; m_timeout = 0;
    m_lu_cnt = 0; m_stall_cnt = 0; m_redirects = 0;
  endtask

  // Expected outputs for the current cycle; then advance the model.
  task automatic model_cycle(output logic [5:0] e);
    bit lu;
    lu = id_valid && ex_valid && ex_is_load && ex_w_ena && (ex_w_addr != 5'd0) &&
         ((id_rs1_use && id_rs1_addr == ex_w_addr) ||
          (id_rs2_use && id_rs2_addr == ex_w_addr));
    e = NONE;
    if (m_mem) begin
      if (lsu_busy) e = STALL;
      else m_mem = 0;
    end else if (m_mdu) begin
      if (mdu_done) m_mdu = 0;
      else begin
        e = STALL;
        if (lsu_busy) m_mem = 1;
        else begin
          if (m_elapsed < MT) m_elapsed++;
          if (m_elapsed >= MT) m_timeout = 1;
        end
      end
    end else if (lsu_busy) begin
      e = STALL; m_mem = 1;
    end else if (ex_redirect) begin
      e = FLUSH; m_flush_left = FC - 1; m_redirects++;
    end else if (m_flush_left > 0) begin
      e = FLUSH; m_flush_left--;
    end else if (mdu_start) begin
      m_mdu = 1; m_elapsed = 0;
    end else if (lu) begin
      e = BUBBLE;
    end
    if (e == BUBBLE) m_lu_cnt++;
    if (e[3]) m_stall_cnt++;
  endtask

  task automatic test_reset();
    idle();
    reset = 1;
    lsu_busy = 1;
    @(negedge clock);
    @(negedge clock);
    lsu_busy = 0;
    reset = 0;
    #1;
    vectors++;
    if (obs !== NONE || ctrl_state !== 2'd0 || mdu_timeout !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_state obs=%b st=%0d to=%b, want 000000 0 0", obs, ctrl_state, mdu_timeout);
    end
    @(negedge clock);
    mdu_start = 1;
    @(negedge clock);
    mdu_start = 0;
    #1;
    vectors++;
    if (ctrl_state !== 2'd1 || obs !== STALL) begin
      miscompares++;
      $display("FAIL reset_pre_mdu st=%0d obs=%b, want 1 111000", ctrl_state, obs);
    end
    reset = 1;
    @(negedge clock);
    reset = 0;
    #1;
    vectors++;
    if (ctrl_state !== 2'd0 || obs !== NONE) begin
      miscompares++;
      $display("FAIL reset_abort st=%0d obs=%b, want 0 000000", ctrl_state, obs);
    end
    @(negedge clock);
  endtask

  task automatic test_load_use();
    pulse_reset();
    set_load_use(5'd5);
    #1;
    vectors++;
    if (obs !== BUBBLE || ctrl_state !== 2'd0) begin
      miscompares++;
      $display("FAIL load_use obs=%b st=%0d, want 100100 0", obs, ctrl_state);
    end
    @(negedge clock);
    ex_valid = 0;  // the bubble now sits in EX
    #1;
    vectors++;
    if (obs !== NONE) begin
      miscompares++;
      $display("FAIL load_use_clear obs=%b, want 000000", obs);
    end
    @(negedge clock);
    set_load_use(5'd0);
    id_rs2_addr = 5'd0;
    #1;
    vectors++;
    if (obs !== NONE) begin
      miscompares++;
      $display("FAIL load_use_x0 obs=%b, want 000000", obs);
    end
    @(negedge clock);
    set_load_use(5'd9);
    id_rs1_addr = 5'd9;
    id_rs1_use = 0;
    #1;
    vectors++;
    if (obs !== NONE) begin
      miscompares++;
      $display("FAIL load_use_unused_rs1 obs=%b, want 000000", obs);
    end
    id_rs1_use = 1;
    #1;
    vectors++;
    if (obs !== BUBBLE) begin
      miscompares++;
      $display("FAIL load_use_rs1 obs=%b, want 100100", obs);
    end
    @(negedge clock);
    idle();
  endtask

  task automatic test_redirect();
    pulse_reset();
    ex_redirect = 1;
    #1;
    vectors++;
    if (obs !== FLUSH || ctrl_state !== 2'd0) begin
      miscompares++;
      $display("FAIL redirect_n obs=%b st=%0d, want 000011 0", obs, ctrl_state);
    end
    @(negedge clock);
    ex_redirect = 0;
    #1;
    vectors++;
    if (obs !== FLUSH || ctrl_state !== 2'd3) begin
      miscompares++;
      $display("FAIL redirect_n1 obs=%b st=%0d, want 000011 3", obs, ctrl_state);
    end
    @(negedge clock);
    #1;
    vectors++;
    if (obs !== NONE || ctrl_state !== 2'd0) begin
      miscompares++;
      $display("FAIL redirect_n2 obs=%b st=%0d, want 000000 0", obs, ctrl_state);
    end
    @(negedge clock);
  endtask

  task automatic test_mdu();
    pulse_reset();
    mdu_start = 1;
    #1;
    vectors++;
    if (obs !== NONE || ctrl_state !== 2'd0) begin
      miscompares++;
      $display("FAIL mdu_issue obs=%b st=%0d, want 000000 0", obs, ctrl_state);
    end
    @(negedge clock);
    mdu_start = 0;
    for (int k = 1; k <= 9; k++) begin
      #1;
      vectors++;
      if (obs !== STALL || ctrl_state !== 2'd1) begin
        miscompares++;
        $display("FAIL mdu_wait_%0d obs=%b st=%0d, want 111000 1", k, obs, ctrl_state);
      end
      @(negedge clock);
    end
    mdu_done = 1;
    #1;
    vectors++;
    if (obs !== NONE) begin
      miscompares++;
      $display("FAIL mdu_done obs=%b, want 000000", obs);
    end
    @(negedge clock);
    mdu_done = 0;
    #1;
    vectors++;
    if (ctrl_state !== 2'd0 || obs !== NONE) begin
      miscompares++;
      $display("FAIL mdu_return st=%0d obs=%b, want 0 000000", ctrl_state, obs);
    end
    @(negedge clock);
  endtask

  task automatic test_mdu_timeout();
    pulse_reset();
    mdu_start = 1;
    @(negedge clock);
    mdu_start = 0;
    for (int k = 1; k <= 6; k++) begin
      #1;
      vectors++;
      if (mdu_timeout !== (k >= 5) || ctrl_state !== 2'd1) begin
        miscompares++;
        $display("FAIL mdu_timeout_%0d to=%b st=%0d, want %0d 1", k, mdu_timeout, ctrl_state, (k >= 5));
      end
      @(negedge clock);
    end
    mdu_done = 1;
    @(negedge clock);
    mdu_done = 0;
    for (int k = 0; k < 3; k++) begin
      #1;
      vectors++;
      if (mdu_timeout !== 1'b1 || ctrl_state !== 2'd0) begin
        miscompares++;
        $display("FAIL mdu_timeout_sticky to=%b st=%0d, want 1 0", mdu_timeout, ctrl_state);
      end
      @(negedge clock);
    end
    pulse_reset();
    #1;
    vectors++;
    if (mdu_timeout !== 1'b0) begin
      miscompares++;
      $display("FAIL mdu_timeout_reset to=%b, want 0", mdu_timeout);
    end
    @(negedge clock);
  endtask

  task automatic test_mdu_mem_wait();
    logic [1:0] want_st [3:9];
    logic [5:0] want_obs [3:9];
    logic       want_to [3:9];
    want_st  = '{2'd1, 2'd2, 2'd2, 2'd2, 2'd1, 2'd1, 2'd1};
    want_obs = '{STALL, STALL, STALL, NONE, STALL, STALL, STALL};
    want_to  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    pulse_reset();
    mdu_start = 1;
    @(negedge clock);
    mdu_start = 0;
    @(negedge clock);
    @(negedge clock);
    for (int k = 3; k <= 9; k++) begin
      lsu_busy = (k <= 5);
      #1;
      vectors++;
      if (ctrl_state !== want_st[k] || obs !== want_obs[k] || mdu_timeout !== want_to[k]) begin
        miscompares++;
        $display("FAIL mdu_mem_%0d st=%0d obs=%b to=%b, want %0d %b %b",
                 k, ctrl_state, obs, mdu_timeout, want_st[k], want_obs[k], want_to[k]);
      end
      @(negedge clock);
    end
    idle();
  endtask

  task automatic test_priority();
    pulse_reset();
    set_load_use(5'd5);
    ex_redirect = 1;
    lsu_busy = 1;
    #1;
    vectors++;
    if (obs !== STALL || ctrl_state !== 2'd0) begin
      miscompares++;
      $display("FAIL prio_all obs=%b st=%0d, want 111000 0", obs, ctrl_state);
    end
    @(negedge clock);
    idle();
    #1;
    vectors++;
    if (ctrl_state !== 2'd2 || obs !== NONE) begin
      miscompares++;
      $display("FAIL prio_memwait st=%0d obs=%b, want 2 000000", ctrl_state, obs);
    end
    @(negedge clock);
    #1;
    vectors++;
    if (ctrl_state !== 2'd0) begin
      miscompares++;
      $display("FAIL prio_return st=%0d, want 0", ctrl_state);
    end
    @(negedge clock);
  endtask

  task automatic test_flush_mem_wait();
    logic [1:0] want_st [0:4];
    logic [5:0] want_obs [0:4];
    want_st  = '{2'd3, 2'd2, 2'd2, 2'd3, 2'd0};
    want_obs = '{STALL, STALL, NONE, FLUSH, NONE};
    pulse_reset();
    ex_redirect = 1;
    @(negedge clock);
    ex_redirect = 0;
    for (int k = 0; k <= 4; k++) begin
      lsu_busy = (k <= 1);
      #1;
      vectors++;
      if (ctrl_state !== want_st[k] || obs !== want_obs[k]) begin
        miscompares++;
        $display("FAIL flush_mem_%0d st=%0d obs=%b, want %0d %b", k, ctrl_state, obs, want_st[k], want_obs[k]);
      end
      @(negedge clock);
    end
    idle();
  endtask

  task automatic test_random(input int n);
    logic [5:0] e;
    logic [1:0] est;
    bit         eto;
    pulse_reset();
    model_clear();
    for (int i = 0; i < n; i++) begin
      id_valid    = ($urandom_range(0, 9) < 8);
      id_rs1_use  = $urandom_range(0, 1);
      id_rs2_use  = $urandom_range(0, 1);
      id_rs1_addr = 5'($urandom_range(0, 3));
      id_rs2_addr = 5'($urandom_range(0, 3));
      ex_valid    = ($urandom_range(0, 9) < 8);
      ex_w_ena    = ($urandom_range(0, 9) < 8);
      ex_w_addr   = 5'($urandom_range(0, 3));
      ex_is_load  = $urandom_range(0, 1);
      ex_redirect = ($urandom_range(0, 99) < 8);
      mdu_start   = ($urandom_range(0, 99) < 10);
      mdu_done    = ($urandom_range(0, 99) < 10);
      lsu_busy    = ($urandom_range(0, 99) < 12);
      reset       = ($urandom_range(0, 199) == 0);
      #1;
      if (reset) begin
        model_clear();
      end else begin
        est = m_mem ? 2'd2 : m_mdu ? 2'd1 : (m_flush_left > 0) ? 2'd3 : 2'd0;
        eto = m_timeout;
        model_cycle(e);
        vectors++;
        if (obs !== e || ctrl_state !== est || mdu_timeout !== eto) begin
          miscompares++;
          $display("FAIL random_%0d obs=%b st=%0d to=%b, want %b %0d %b",
                   i, obs, ctrl_state, mdu_timeout, e, est, eto);
        end
      end
      @(negedge clock);
    end
    reset = 0;
    idle();
    #1;
`ifdef PIPE_HAZARD_CTRL_PERF_EN
    vectors++;
    if (perf_loaduse_cnt !== 32'(m_lu_cnt) || perf_stall_cnt !== 32'(m_stall_cnt) ||
        perf_flush_cnt !== 32'(m_redirects)) begin
      miscompares++;
      $display("FAIL perf_counts lu=%0d st=%0d fl=%0d, want %0d %0d %0d",
               perf_loaduse_cnt, perf_stall_cnt, perf_flush_cnt, m_lu_cnt, m_stall_cnt, m_redirects);
    end
`endif
    @(negedge clock);
  endtask

  initial begin
    idle();
    reset = 1;
    @(negedge clock);
    test_reset();
    test_load_use();
    test_redirect();
    test_mdu();
    test_mdu_timeout();
    test_mdu_mem_wait();
    test_priority();
    test_flush_mem_wait();
    test_random(3000);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central stall/flush/bubble controller for the 5-stage in-order pipeline.
- Drives the stall, flush and nop controls of the IF/ID and ID/EX pipeline registers. Its inputs are:
  - ID source-register info;
  - EX destination, load, redirect and multi-cycle-op status;
  - the MEM-stage LSU busy flag.
- Resolves load-use hazards, branch/jump redirects, multi-cycle MDU waits and memory waits with a fixed priority.

Parameters:
- FLUSH_CYCLES, 2, cycles if_flush/id_flush stay asserted after a redirect (covers in-flight fetch); legal 1..7
- MDU_TIMEOUT, 64, max cycles in MDU_WAIT before mdu_timeout is raised; legal 2..255

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- id_valid  in  1  ID holds a valid instruction
- id_rs1_use  in  1  ID instruction reads rs1
- id_rs2_use  in  1  ID instruction reads rs2
- id_rs1_addr  in  5  rs1 index
- id_rs2_addr  in  5  rs2 index
- ex_valid  in  1  EX holds a valid instruction
- ex_w_ena  in  1  EX instruction writes the regfile
- ex_w_addr  in  5  EX destination index
- ex_is_load  in  1  EX instruction is a load
- ex_redirect  in  1  EX resolved a taken branch/jump (one-cycle pulse)
- mdu_start  in  1  EX issues a multi-cycle mul/div this cycle
- mdu_done  in  1  MDU result ready (one-cycle pulse)
- lsu_busy  in  1  MEM stage waiting on memory
- if_stall  out  1  hold PC and IF/ID
- id_stall  out  1  hold ID/EX (drives its stall input)
- ex_stall  out  1  hold EX/MEM
- id_nop  out  1  insert bubble into ID/EX
- if_flush  out  1  squash IF/ID
- id_flush  out  1  squash ID/EX
- ctrl_state  out  2  0=RUN 1=MDU_WAIT 2=MEM_WAIT 3=FLUSH
- mdu_timeout  out  1  sticky error; cleared only by reset

Behaviour:
- Reset: state RUN, flush counter 0, MDU counter 0, saved state RUN, mdu_timeout 0.
  - All stall/flush/nop outputs read 0 in the cycle after reset; ctrl_state=0.
  - Reset mid-operation aborts any wait or flush immediately.
- Outputs are combinational from the current state and inputs; state updates on the rising clock edge.
- Priority when events coincide: lsu_busy > MDU_WAIT > redirect/FLUSH > load-use > none.
- Load-use hazard, evaluated in RUN only. It exists when all of the following hold:
  - id_valid & ex_valid & ex_is_load & ex_w_ena & ex_w_addr!=0;
  - the address matches id_rs1_addr with id_rs1_use, or id_rs2_addr with id_rs2_use.
- Load-use response: if_stall=1 and id_nop=1 for exactly that cycle; id_stall=0. No state change; the bubble clears the hazard next cycle.
- RUN state:
  - lsu_busy=1: save RUN, go MEM_WAIT; assert if_stall/id_stall/ex_stall this cycle.
  - Else ex_redirect=1: assert if_flush=1 and id_flush=1 this cycle, load the flush counter with FLUSH_CYCLES-1. If FLUSH_CYCLES>1 go FLUSH, else stay RUN. Redirect wins over load-use: id_nop=0, if_stall=0.
  - Else mdu_start=1: go MDU_WAIT, clear the MDU counter. Stalls begin next cycle.
  - Else: load-use logic applies.
- MDU_WAIT state:
  - if_stall=id_stall=ex_stall=1; MDU counter increments each cycle, saturating at MDU_TIMEOUT.
  - mdu_done=1: drop all stalls that same cycle, go RUN.
  - lsu_busy=1 (and no mdu_done): save MDU_WAIT, go MEM_WAIT; the MDU counter freezes.
  - Counter reaching MDU_TIMEOUT sets mdu_timeout=1. The state stays MDU_WAIT.
- MEM_WAIT state:
  - if_stall=id_stall=ex_stall=1.
  - lsu_busy=0: stalls drop that cycle; return to the saved state (RUN or MDU_WAIT).
  - An ex_redirect arriving while in MEM_WAIT is ignored; EX is frozen, so the pulse repeats after release.
- FLUSH state:
  - if_flush=id_flush=1; the flush counter decrements each cycle; counter==0 at that edge -> RUN.
  - A new ex_redirect reloads the counter with FLUSH_CYCLES-1.
  - lsu_busy=1: save FLUSH and the counter value, go MEM_WAIT; on return, resume the remaining flush cycles.
- mdu_done outside MDU_WAIT: ignored.
- mdu_start outside RUN: ignored; EX is stalled, so the issuer must hold it.

Optional Feature:
- PIPE_HAZARD_CTRL_PERF_EN defined: adds three 32-bit wrapping output counters, reset 0:
  - perf_loaduse_cnt, +1 per load-use bubble;
  - perf_stall_cnt, +1 per cycle with ex_stall=1;
  - perf_flush_cnt, +1 per redirect accepted.
- Not defined: the ports and counter logic are absent; all other behaviour is identical.

Test Plan:
- Load-use: ex_is_load=1, ex_w_addr=5, id_rs2_addr=5, id_rs2_use=1, all valids 1 -> exactly 1 cycle of if_stall=1, id_nop=1; none if ex_w_addr=0.
- Redirect with FLUSH_CYCLES=2: ex_redirect pulse at cycle N -> if_flush=id_flush=1 at cycles N and N+1; ctrl_state=3 at N+1, 0 at N+2.
- MDU: mdu_start at N, mdu_done at N+10 -> if/id/ex_stall=1 for cycles N+1..N+9 and 0 at N+10; ctrl_state returns to 0.
- MDU_TIMEOUT=4 with no mdu_done -> mdu_timeout=1 after 4 cycles in MDU_WAIT, held until reset.
- lsu_busy for 3 cycles during MDU_WAIT -> ctrl_state=2 for those cycles, then returns to 1; the MDU counter does not advance while in MEM_WAIT.
- Simultaneous lsu_busy + ex_redirect + load-use in RUN -> MEM_WAIT with stalls only: if_flush=0, id_nop=0.
